fir_mac_sched: RTL and testbench
================================

FIR_MAC_SCHED -- requirements
Module: fir_mac_sched

Interface
REQ-001 Parameter DW, default 16, SHALL set the sample, coefficient and result width.
REQ-002 Parameter NTAP, default 9, SHALL be fixed at 9; any other value SHALL fail elaboration.
REQ-003 clk  input  1  SHALL be the only clock; every register SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 x  input  DW signed  SHALL carry the input sample.
REQ-006 in_valid  input  1  SHALL mark x valid.
REQ-007 in_ready  output  1  SHALL mean a sample can be accepted.
REQ-008 y  output  DW signed  SHALL carry the filter result.
REQ-009 out_valid  output  1  SHALL mark y valid.
REQ-010 out_ready  input  1  SHALL mean the consumer takes y.
REQ-011 busy  output  1  SHALL be high while state is not IDLE.

Function
REQ-012 Coefficients SHALL be c[0..8] = {2, 0, 6, 18, -32, 18, 6, 0, 2}, where c[0] applies to the newest sample.
REQ-013 The block SHALL use one multiplier and one accumulator adder, shared across all taps over time.
REQ-014 The FSM SHALL have three states: IDLE, MAC and HOLD.
REQ-015 IDLE: in_ready=1; when in_valid=1, the block SHALL write x at wr_ptr, set acc=0 and tap=0, and go to MAC.
REQ-016 wr_ptr SHALL advance on each accepted sample and SHALL wrap from 8 to 0.
REQ-017 MAC: each cycle, acc SHALL be set to add(acc, trunc_DW(c[tap]*buf[newest-tap mod 9])), and tap SHALL increment; in_ready SHALL be 0.
REQ-018 After tap 8, the FSM SHALL go to HOLD with y=acc and out_valid=1; the total latency from accept to out_valid is 10 cycles.
REQ-019 HOLD: y and out_valid SHALL stay stable until out_ready=1; on that cycle the FSM SHALL return to IDLE.
REQ-020 Products and sums SHALL wrap at DW bits two's-complement; there is no saturation.
REQ-021 in_valid outside IDLE SHALL be ignored; the sample is not consumed.
REQ-022 Throughput SHALL be at most one sample per 11 cycles (accept, 9 MAC cycles, HOLD with out_ready=1).

Reset
REQ-023 rst=1 SHALL clear all buffer entries, acc, tap and wr_ptr to 0, and set state IDLE, out_valid=0, y=0 and busy=0 on the next edge.
REQ-024 Reset during MAC or HOLD SHALL abandon the computation; no out_valid SHALL follow.
REQ-025 After reset, in_ready SHALL be 1 in the first cycle with rst=0.

Configuration
REQ-026 With FIR_EXACT_ADD_EN defined, the accumulator SHALL use an exact DW-bit wrapping adder.
REQ-027 Without FIR_EXACT_ADD_EN, the accumulator SHALL use an instance of the team's add16se_2U6 approximate adder (A=product, B=acc); DW SHALL then be 16.

Structure
REQ-028 Package fir_pkg SHALL hold NTAP, the coefficient array constant and the state enum (IDLE, MAC, HOLD).
REQ-029 Sub-module fir_acc_add SHALL wrap the adder choice made by FIR_EXACT_ADD_EN.

Verification
REQ-030 Exact build, impulse x=1 then eight zeros: y sequence SHALL be 2, 0, 6, 18, -32, 18, 6, 0, 2; the tenth sample (0) SHALL give 0.
REQ-031 Exact build, step x=1 repeated: y SHALL be 2, 2, 8, 26, -6, 12, 18, 18, 20, 20.
REQ-032 Exact build, single x=0x4000 after reset: first y SHALL be 0x8000 (wrap); the center-tap output (5th) SHALL be 0x0000.
REQ-033 Backpressure, out_ready=0 for 5 cycles in HOLD: y and out_valid SHALL stay stable, in_ready SHALL stay 0, and a held in_valid SHALL be accepted one cycle after out_ready rises.
REQ-034 rst pulsed at MAC tap 4: out_valid SHALL stay 0; the next impulse x=1 SHALL give y=2 (history cleared).
REQ-035 Approximate build: a random stream of 1000 samples SHALL match, bit for bit, a model that uses the add16se_2U6 behavioural function.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared tap count, coefficient table and FSM state type for fir_mac_sched
package fir_pkg;
  localparam int NTAP = 9;
  localparam int COEF [NTAP] = '{2, 0, 6, 18, -32, 18, 6, 0, 2};
  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;
endpackage

// File: rtl/add16se_2U6.sv
// add16se_2U6: approximate 16-bit adder, exact upper 14 bits, OR-approximated low 2 bits (no carry out of them)
//   a, b : addends; o : wrapped 16-bit approximate sum
module add16se_2U6 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] o
);
  assign o = {a[15:2] + b[15:2], a[1:0] | b[1:0]};
endmodule

// File: rtl/fir_acc_add.sv
// fir_acc_add: accumulator adder, exact with FIR_EXACT_ADD_EN defined, otherwise add16se_2U6 (DW must be 16)
//   a : product, b : accumulator, s : DW-bit wrapped sum
module fir_acc_add #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] s
);
`ifdef FIR_EXACT_ADD_EN
  assign s = a + b;
`else
  if (DW != 16) begin : g_dw_chk
    $error("fir_acc_add: approximate adder requires DW == 16");
  end
  add16se_2U6 u_add (.a(a), .b(b), .o(s));
`endif
endmodule

// File: rtl/fir_mac_sched.sv
// fir_mac_sched: 9-tap FIR, one shared multiplier and accumulator, one sample per 11 cycles
//   clk, rst             : clock, synchronous active-high reset
//   x, in_valid, in_ready : input sample handshake (accepted only in IDLE)
//   y, out_valid, out_ready : result handshake (held in HOLD until out_ready)
//   busy                 : high while not IDLE
//   FIR_EXACT_ADD_EN     : selects the exact accumulator adder instead of add16se_2U6
module fir_mac_sched
  import fir_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NTAP = fir_pkg::NTAP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] x,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [DW-1:0] y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);
  if (NTAP != 9) begin : g_ntap_chk
    $error("fir_mac_sched: NTAP must be 9");
  end
  state_t        state;
  logic [DW-1:0] buffer [NTAP];
  logic [DW-1:0] acc, coef, prod, sum;
  logic [3:0]    wr_ptr, tap, rd_ptr;
  logic [4:0]    rd_sum;
  // wr_ptr already points past the newest sample, so newest-tap = wr_ptr-1-tap (mod 9)
  always_comb begin
    rd_sum = 5'(wr_ptr) + 5'd8 - 5'(tap);
    rd_ptr = rd_sum >= 5'd9 ? 4'(rd_sum - 5'd9) : rd_sum[3:0];
    coef   = DW'(COEF[tap]);
    prod   = coef * buffer[rd_ptr];
  end
  fir_acc_add #(.DW(DW)) u_acc_add (.a(prod), .b(acc), .s(sum));
  assign in_ready = state == IDLE;
  assign busy     = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      tap       <= '0;
      wr_ptr    <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < NTAP; i++) buffer[i] <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          buffer[wr_ptr] <= x;
          wr_ptr         <= wr_ptr == 4'(NTAP - 1) ? 4'd0 : wr_ptr + 4'd1;
          acc            <= '0;
          tap            <= '0;
          state          <= MAC;
        end
        MAC: begin
          acc <= sum;
          tap <= tap + 4'd1;
          if (tap == 4'(NTAP - 1)) begin
            y         <= sum;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac_sched.sv
// tb_fir_mac_sched: directed and random checks of fir_mac_sched handshake, latency and filter output
module tb_fir_mac_sched;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] x = '0;
  logic [15:0] y;
  logic        in_ready, out_valid, busy;
  int          checks = 0, failures = 0;
  int          coefs [9] = '{2, 0, 6, 18, -32, 18, 6, 0, 2};
  logic [15:0] hist [9];

  always #5 clk = ~clk;

  fir_mac_sched #(.DW(16), .NTAP(9)) dut (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  function automatic logic [15:0] add_model(input logic [15:0] a, input logic [15:0] b);
`ifdef FIR_EXACT_ADD_EN
    return a + b;
`else
    logic [13:0] hi;
    hi = a[15:2] + b[15:2];
    return {hi, a[1:0] | b[1:0]};
`endif
  endfunction

  function automatic logic [15:0] model_push(input logic [15:0] s);
    logic [15:0] acc, c, p;
    for (int i = 8; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
    acc = '0;
    for (int t = 0; t < 9; t++) begin
      c   = 16'(coefs[t]);
      p   = c * hist[t];
      acc = add_model(p, acc);
    end
    return acc;
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) hist[i] = '0;
  endtask

  task automatic send(input logic [15:0] s, output logic [15:0] r, output int lat);
    @(negedge clk);
    x = s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    r = y;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks += 4;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    if (y !== 16'h0000) begin failures++; $display("FAIL reset_y got=%h want=0000", y); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
  endtask

  task automatic test_impulse;
    int exp [10] = '{2, 0, 6, 18, -32, 18, 6, 0, 2, 0};
    logic [15:0] r;
    int lat;
    do_reset;
    for (int i = 0; i < 10; i++) begin
      send(i == 0 ? 16'd1 : 16'd0, r, lat);
      checks++;
      if (r !== 16'(exp[i])) begin failures++; $display("FAIL impulse[%0d] got=%h want=%h", i, r, 16'(exp[i])); end
      if (i == 0) begin
        checks++;
        if (lat != 10) begin failures++; $display("FAIL latency got=%0d want=10", lat); end
      end
    end
  endtask

  task automatic test_step;
    int tbl [10] = '{2, 2, 8, 26, -6, 12, 18, 18, 20, 20};
    logic [15:0] r, e;
    int lat;
    do_reset;
    for (int i = 0; i < 10; i++) begin
`ifdef FIR_EXACT_ADD_EN
      e = 16'(tbl[i]);
`else
      e = model_push(16'd1);
`endif
      send(16'd1, r, lat);
      checks++;
      if (r !== e) begin failures++; $display("FAIL step[%0d] got=%h want=%h", i, r, e); end
    end
  endtask

  task automatic test_wrap;
    logic [15:0] r;
    int lat;
    do_reset;
    send(16'h4000, r, lat);
    checks++;
    if (r !== 16'h8000) begin failures++; $display("FAIL wrap_first got=%h want=8000", r); end
    for (int i = 1; i < 5; i++) send(16'h0000, r, lat);
    checks++;
    if (r !== 16'h0000) begin failures++; $display("FAIL wrap_center got=%h want=0000", r); end
  endtask

  task automatic test_backpressure;
    int lat;
    do_reset;
    @(negedge clk);
    x = 16'd1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 30) begin @(negedge clk); lat++; end
    checks++;
    if (!out_valid) begin failures++; $display("FAIL bp_timeout got=%b want=1", out_valid); end
    x = 16'd5;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (y !== 16'd2 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got y=%h ov=%b ir=%b want y=0002 ov=1 ir=0", k, y, out_valid, in_ready);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_accept got busy=%b ir=%b want busy=1 ir=0", busy, in_ready); end
    lat = 1;
    while (!out_valid && lat < 30) begin @(negedge clk); lat++; end
    checks++;
    if (y !== 16'd10 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_second got y=%h ov=%b want y=000a ov=1", y, out_valid); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int exp [3] = '{2, 0, 6};
    logic [15:0] r;
    logic seen;
    int lat;
    do_reset;
    send(16'd3, r, lat);
    checks++;
    if (r !== 16'd6) begin failures++; $display("FAIL mid_pre got=%h want=0006", r); end
    @(negedge clk);
    x = 16'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL mid_idle got busy=%b ir=%b want busy=0 ir=1", busy, in_ready); end
    seen = 1'b0;
    repeat (15) begin @(negedge clk); seen |= out_valid; end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL mid_no_out got=%b want=0", seen); end
    for (int i = 0; i < 3; i++) begin
      send(i == 0 ? 16'd1 : 16'd0, r, lat);
      checks++;
      if (r !== 16'(exp[i])) begin failures++; $display("FAIL mid_after[%0d] got=%h want=%h", i, r, 16'(exp[i])); end
    end
  endtask

  task automatic test_random;
    logic [15:0] s, r, e;
    int lat;
    do_reset;
    for (int i = 0; i < 1000; i++) begin
      s = 16'($urandom);
      e = model_push(s);
      send(s, r, lat);
      checks++;
      if (r !== e) begin failures++; $display("FAIL random[%0d] x=%h got=%h want=%h", i, s, r, e); end
    end
  endtask

  initial begin
    test_reset;
    test_impulse;
    test_step;
    test_wrap;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
